floo_link_buffer: RTL

- Elastic, full-throughput buffer on one FlooNoC link channel (req, rsp or wide) between a tile's router output and the neighbouring tile's router input.
- Breaks the long inter-tile timing path with registered outputs.
- Absorbs back-pressure up to Depth flits.
- Exposes occupancy and stall/flit performance counters to the tile.
- Instantiated once per channel per mesh direction at the tile boundary.

---
 rtl/floo_pkg.sv | 10 +
 rtl/floo_link_perf_cnt.sv | 50 +++++
 rtl/floo_link_buffer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/floo_pkg.sv
// Shared FlooNoC constants used by the link-level buffering blocks.
package floo_pkg;

    // Default width of the link performance counters.
    localparam int unsigned DefaultCntWidth = 32;

    // Default number of flits held by one link buffer.
    localparam int unsigned LinkBufDepth = 2;

endpackage : floo_pkg

// File: rtl/floo_link_perf_cnt.sv
// Saturating stall/flit counter pair for one link channel.
module floo_link_perf_cnt
    import floo_pkg::*;
#(
    parameter int unsigned CntWidth = DefaultCntWidth
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                stall_i,
    input  logic                flit_i,
    output logic [CntWidth-1:0] stall_cnt_o,
    output logic [CntWidth-1:0] flit_cnt_o
);

    logic [CntWidth-1:0] stall_cnt_d, stall_cnt_q;
    logic [CntWidth-1:0] flit_cnt_d, flit_cnt_q;

    // Next counter values: flush on clear, otherwise count up and stick at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flit_cnt_d  = flit_cnt_q;
        if (clear_i) begin
            stall_cnt_d = '0;
            flit_cnt_d  = '0;
        end else begin
            if (stall_i && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (flit_i && (flit_cnt_q != '1)) begin
                flit_cnt_d = flit_cnt_q + 1'b1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
            flit_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flit_cnt_q  <= flit_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flit_cnt_o  = flit_cnt_q;

endmodule : floo_link_perf_cnt

// File: rtl/floo_link_buffer.sv
// Elastic full-throughput link buffer: registered output stage backed by a
// (Depth-1)-entry circular array, with occupancy and performance counters.
module floo_link_buffer
    import floo_pkg::*;
#(
    parameter type         flit_t   = logic,
    parameter int unsigned Depth    = LinkBufDepth,
    parameter int unsigned CntWidth = DefaultCntWidth
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  flit_t                  data_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output flit_t                  data_o,
    output logic [$clog2(Depth):0] usage_o,
    output logic [CntWidth-1:0]    stall_cnt_o,
    output logic [CntWidth-1:0]    flit_cnt_o
);

    localparam int unsigned AddrWidth = $clog2(Depth);
    localparam int unsigned ArrDepth  = Depth - 1;

    typedef logic [AddrWidth-1:0] ptr_t;
    typedef logic [AddrWidth:0]   usage_t;

    localparam ptr_t   PtrLast  = ptr_t'(Depth - 2);
    localparam usage_t UsageMax = usage_t'(Depth);

    if ((Depth < 2) || (Depth > 16)) begin : gen_depth_check
        $error("floo_link_buffer: Depth must be within 2..16");
    end

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == PtrLast) ? '0 : ptr_t'(p + 1'b1);
    endfunction

    flit_t  mem_d [ArrDepth];
    flit_t  mem_q [ArrDepth];
    ptr_t   rd_ptr_d, rd_ptr_q;
    ptr_t   wr_ptr_d, wr_ptr_q;
    usage_t usage_d, usage_q;
    logic   out_valid_d, out_valid_q;
    flit_t  out_data_d, out_data_q;
    logic   ready_d, ready_q;

    logic push, pop, arr_empty, bypass;

    // Next-state for the output stage, array pointers, occupancy and ready.
    always_comb begin
        push        = valid_i & ready_q;
        pop         = out_valid_q & ready_i;
        // Array holds everything except the flit sitting in the output register.
        arr_empty   = (usage_q == {{AddrWidth{1'b0}}, out_valid_q});
        // An incoming flit lands directly in the output register when nothing
        // older is queued and the register is free (or being vacated).
        bypass      = push & arr_empty & (pop | ~out_valid_q);

        mem_d       = mem_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        usage_d     = usage_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (clear_i) begin
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            usage_d     = '0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
        end else begin
            if (pop && !arr_empty) begin
                out_data_d = mem_q[rd_ptr_q];
                rd_ptr_d   = ptr_inc(rd_ptr_q);
            end else if (bypass) begin
                out_data_d  = data_i;
                out_valid_d = 1'b1;
            end else if (pop) begin
                out_valid_d = 1'b0;
            end

            if (push && !bypass) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end

            usage_d = usage_q + usage_t'(push) - usage_t'(pop);
        end

        ready_d = (usage_d < UsageMax);
    end

    // Control and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            usage_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            ready_q     <= 1'b1;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            usage_q     <= usage_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            ready_q     <= ready_d;
        end
    end

    // Flit storage array; contents need no reset.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    floo_link_perf_cnt #(
        .CntWidth(CntWidth)
    ) i_perf_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (clear_i),
        .stall_i    (out_valid_q & ~ready_i),
        .flit_i     (pop),
        .stall_cnt_o(stall_cnt_o),
        .flit_cnt_o (flit_cnt_o)
    );

    assign ready_o = ready_q;
    assign valid_o = out_valid_q;
    assign data_o  = out_data_q;
    assign usage_o = usage_q;

`ifndef SYNTHESIS
    a_data_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (out_valid_q && !ready_i && !clear_i) |=> (out_valid_q && $stable(out_data_q)));
    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (usage_q == UsageMax) |-> !push);
    a_usage_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        usage_q <= UsageMax);
`endif

endmodule : floo_link_buffer
